// File: rtl/score_engine.sv
// Rhythm-game scoring engine: internal combo tracking, combo-tiered multiplier,
// and a two-stage saturating score pipeline gated by the top-level game state.
module score_engine #(
   parameter int unsigned LANES       = 2,
   parameter int unsigned SCORE_W     = 16,
   parameter int unsigned COMBO_W     = 8,
   parameter int unsigned MULT_W      = 5,
   parameter int unsigned COMBO_STEP  = 16,
   parameter int unsigned MAX_MULT    = 17,
   parameter int unsigned PERFECT_PTS = 4,
   parameter int unsigned GOOD_PTS    = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [1:0]         current_state,
   input  logic [LANES-1:0]   hit,
   input  logic [LANES-1:0]   perfect,
   input  logic [LANES-1:0]   miss,
   output logic [SCORE_W-1:0] score,
   output logic [COMBO_W-1:0] combo,
   output logic [COMBO_W-1:0] max_combo,
   output logic [MULT_W-1:0]  multiplier,
   output logic               score_upd,
   output logic               saturated
);

   localparam logic [1:0] ST_IDLE        = 2'd0;
   localparam logic [1:0] ST_SONG_SELECT = 2'd1;
   localparam logic [1:0] ST_GAME_PLAY   = 2'd2;

   localparam int unsigned MAX_PTS = (PERFECT_PTS > GOOD_PTS) ? PERFECT_PTS : GOOD_PTS;
   localparam int unsigned BASE_W  = $clog2(LANES * MAX_PTS + 1);
   localparam int unsigned CNT_W   = $clog2(LANES + 1);
   localparam int unsigned PROD_W  = BASE_W + MULT_W;
   localparam int unsigned SUM_W   = ((SCORE_W > PROD_W) ? SCORE_W : PROD_W) + 1;
   localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

   logic [LANES-1:0]   eff_hit_c;
   logic [BASE_W-1:0]  base_c;
   logic [CNT_W-1:0]   cnt_c;
   logic [COMBO_W:0]   combo_sum_c;
   logic [COMBO_W-1:0] combo_nxt_c;

   logic               s1_valid;
   logic [BASE_W-1:0]  s1_base;
   logic [MULT_W-1:0]  s1_mult;

   logic [PROD_W-1:0]  product_c;
   logic [SUM_W-1:0]   sum_c;
   logic               clamp_c;
   logic [SCORE_W-1:0] score_nxt_c;

   // Tier multiplier: 1 with no combo, then one step per COMBO_STEP hits, capped.
   function automatic logic [MULT_W-1:0] mult_of(input logic [COMBO_W-1:0] c);
      int unsigned tier;
      if (c == '0) begin
         tier = 1;
      end else begin
         tier = 2 + (32'(c) - 1) / COMBO_STEP;
         if (tier > MAX_MULT) tier = MAX_MULT;
      end
      return MULT_W'(tier);
   endfunction

   // A lane showing both hit and miss is judged a miss.
   always_comb begin
      eff_hit_c = hit & ~miss;
      base_c    = '0;
      cnt_c     = '0;
      for (int i = 0; i < LANES; i++) begin
         if (eff_hit_c[i]) begin
            base_c = base_c + (perfect[i] ? BASE_W'(PERFECT_PTS) : BASE_W'(GOOD_PTS));
            cnt_c  = cnt_c + CNT_W'(1);
         end
      end
      combo_sum_c = (COMBO_W+1)'(combo) + (COMBO_W+1)'(cnt_c);
      if (|miss)
         combo_nxt_c = '0;
      else if (combo_sum_c[COMBO_W])
         combo_nxt_c = '1;
      else
         combo_nxt_c = combo_sum_c[COMBO_W-1:0];
   end

   // Stage-2 arithmetic is wide enough that the sum never wraps before clamping.
   always_comb begin
      product_c   = PROD_W'(s1_base) * PROD_W'(s1_mult);
      sum_c       = SUM_W'(score) + SUM_W'(product_c);
      clamp_c     = sum_c > SUM_W'(SCORE_MAX);
      score_nxt_c = clamp_c ? SCORE_MAX : sum_c[SCORE_W-1:0];
   end

   // Stage 1: judgement capture and combo tracking.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid   <= 1'b0;
         s1_base    <= '0;
         s1_mult    <= '0;
         combo      <= '0;
         max_combo  <= '0;
         multiplier <= MULT_W'(1);
      end else begin
         case (current_state)
            ST_SONG_SELECT: begin
               s1_valid   <= 1'b0;
               s1_base    <= '0;
               s1_mult    <= '0;
               combo      <= '0;
               max_combo  <= '0;
               multiplier <= MULT_W'(1);
            end
            ST_GAME_PLAY: begin
               s1_valid   <= 1'b1;
               s1_base    <= base_c;
               s1_mult    <= multiplier;
               combo      <= combo_nxt_c;
               max_combo  <= (combo_nxt_c > max_combo) ? combo_nxt_c : max_combo;
               multiplier <= mult_of(combo_nxt_c);
            end
            default: s1_valid <= 1'b0;
         endcase
      end
   end

   // Stage 2: score commit; in-flight points survive any state but SONG_SELECT.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         score     <= '0;
         score_upd <= 1'b0;
         saturated <= 1'b0;
      end else if (current_state == ST_SONG_SELECT) begin
         score     <= '0;
         score_upd <= 1'b0;
         saturated <= 1'b0;
      end else if (s1_valid) begin
         score     <= score_nxt_c;
         score_upd <= product_c != '0;
         if (clamp_c) saturated <= 1'b1;
      end else begin
         score_upd <= 1'b0;
      end
   end

   logic unused_c;
   assign unused_c = (current_state == ST_IDLE);

endmodule

// File: tb/tb_score_engine.sv
// Self-checking bench for score_engine: directed scenarios plus randomized
// stimulus against an integer reference model, on a 16-bit and an 8-bit score instance.
module tb_score_engine;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] SS   = 2'd1;
   localparam logic [1:0] GP   = 2'd2;
   localparam logic [1:0] GO   = 2'd3;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  st;
   logic [1:0]  hit, perf, miss;

   logic [15:0] score;
   logic [7:0]  combo, max_combo;
   logic [4:0]  multiplier;
   logic        score_upd, saturated;

   logic [7:0]  score8;
   logic [7:0]  combo8, max_combo8;
   logic [4:0]  multiplier8;
   logic        score_upd8, saturated8;

   int total = 0;
   int bad   = 0;

   // reference model state; index 0 = 16-bit score, 1 = 8-bit score
   int m_score[2];
   int m_sat[2];
   int m_upd[2];
   int m_combo, m_max, m_pend, m_pend_v;
   int score_max[2] = '{65535, 255};

   always #5 clk = ~clk;

   score_engine dut (
      .clk(clk), .rst(rst), .current_state(st), .hit(hit), .perfect(perf), .miss(miss),
      .score(score), .combo(combo), .max_combo(max_combo), .multiplier(multiplier),
      .score_upd(score_upd), .saturated(saturated));

   score_engine #(.SCORE_W(8)) dut8 (
      .clk(clk), .rst(rst), .current_state(st), .hit(hit), .perfect(perf), .miss(miss),
      .score(score8), .combo(combo8), .max_combo(max_combo8), .multiplier(multiplier8),
      .score_upd(score_upd8), .saturated(saturated8));

   function automatic int mult_ref(input int c);
      int t;
      if (c == 0) return 1;
      t = 2 + (c - 1) / 16;
      return (t > 17) ? 17 : t;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_score[k] = 0; m_sat[k] = 0; m_upd[k] = 0;
      end
      m_combo = 0; m_max = 0; m_pend = 0; m_pend_v = 0;
   endtask

   // One clock edge of game rules, expressed as plain integer arithmetic.
   task automatic model_step();
      int base, cnt;
      if (st == SS) begin
         model_reset();
         return;
      end
      for (int k = 0; k < 2; k++) begin
         if (m_pend_v != 0) begin
            if (m_score[k] + m_pend > score_max[k]) begin
               m_score[k] = score_max[k];
               m_sat[k]   = 1;
            end else begin
               m_score[k] = m_score[k] + m_pend;
            end
            m_upd[k] = (m_pend != 0);
         end else begin
            m_upd[k] = 0;
         end
      end
      m_pend_v = 0;
      if (st == GP) begin
         base = 0; cnt = 0;
         for (int i = 0; i < 2; i++)
            if (hit[i] && !miss[i]) begin
               cnt++;
               base += perf[i] ? 4 : 2;
            end
         m_pend   = base * mult_ref(m_combo);
         m_pend_v = 1;
         if (miss != 2'b00) m_combo = 0;
         else m_combo = (m_combo + cnt > 255) ? 255 : m_combo + cnt;
         if (m_combo > m_max) m_max = m_combo;
      end
   endtask

   task automatic cycle(input logic [1:0] s, input logic [1:0] h, input logic [1:0] p,
                        input logic [1:0] m);
      @(negedge clk);
      st = s; hit = h; perf = p; miss = m;
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0; st = IDLE; hit = '0; perf = '0; miss = '0;
      model_reset();
      #12;
      total++;
      if (score !== 16'd0 || combo !== 8'd0 || max_combo !== 8'd0 || multiplier !== 5'd1 ||
          score_upd !== 1'b0 || saturated !== 1'b0) begin
         bad++;
         $display("FAIL reset_init score=%0d combo=%0d max=%0d mult=%0d upd=%0d sat=%0d exp 0/0/0/1/0/0",
                  score, combo, max_combo, multiplier, score_upd, saturated);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      cycle(SS, 2'b00, 2'b00, 2'b00);
      for (int i = 0; i < 5; i++) cycle(GP, 2'b11, 2'b11, 2'b00);
      total++;
      if (score === 16'd0) begin
         bad++;
         $display("FAIL reset_prep score=%0d exp nonzero", score);
      end
      #2;
      rst = 1'b0;
      model_reset();
      #1;
      total++;
      if (score !== 16'd0 || combo !== 8'd0 || max_combo !== 8'd0 || multiplier !== 5'd1 ||
          saturated !== 1'b0 || score_upd !== 1'b0) begin
         bad++;
         $display("FAIL reset_async score=%0d combo=%0d max=%0d mult=%0d sat=%0d exp 0/0/0/1/0",
                  score, combo, max_combo, multiplier, saturated);
      end
      #1;
      rst = 1'b1;
   endtask

   task automatic test_basic();
      cycle(SS, 2'b00, 2'b00, 2'b00);
      cycle(GP, 2'b01, 2'b01, 2'b00);
      total++;
      if (combo !== 8'd1 || multiplier !== 5'd2 || score !== 16'd0) begin
         bad++;
         $display("FAIL basic_first combo=%0d mult=%0d score=%0d exp 1/2/0", combo, multiplier, score);
      end
      cycle(GP, 2'b01, 2'b01, 2'b00);
      total++;
      if (score !== 16'd4 || score_upd !== 1'b1 || combo !== 8'd2) begin
         bad++;
         $display("FAIL basic_score4 score=%0d upd=%0d combo=%0d exp 4/1/2", score, score_upd, combo);
      end
      cycle(GP, 2'b00, 2'b00, 2'b00);
      total++;
      if (score !== 16'd12 || score_upd !== 1'b1) begin
         bad++;
         $display("FAIL basic_score12 score=%0d upd=%0d exp 12/1", score, score_upd);
      end
      cycle(GP, 2'b00, 2'b00, 2'b00);
      total++;
      if (score !== 16'd12 || score_upd !== 1'b0) begin
         bad++;
         $display("FAIL basic_idle score=%0d upd=%0d exp 12/0", score, score_upd);
      end
   endtask

   task automatic test_tiers();
      for (int i = 0; i < 14; i++) cycle(GP, 2'b10, 2'b00, 2'b00);
      total++;
      if (combo !== 8'd16 || multiplier !== 5'd2) begin
         bad++;
         $display("FAIL tier16 combo=%0d mult=%0d exp 16/2", combo, multiplier);
      end
      cycle(GP, 2'b01, 2'b00, 2'b00);
      total++;
      if (combo !== 8'd17 || multiplier !== 5'd3) begin
         bad++;
         $display("FAIL tier17 combo=%0d mult=%0d exp 17/3", combo, multiplier);
      end
      for (int i = 0; i < 119; i++) cycle(GP, 2'b11, 2'($urandom_range(0, 3)), 2'b00);
      total++;
      if (combo !== 8'd255 || multiplier !== 5'd17) begin
         bad++;
         $display("FAIL tier255 combo=%0d mult=%0d exp 255/17", combo, multiplier);
      end
      for (int i = 0; i < 3; i++) cycle(GP, 2'b11, 2'b11, 2'b00);
      total++;
      if (combo !== 8'd255 || max_combo !== 8'd255 || score !== 16'(m_score[0])) begin
         bad++;
         $display("FAIL tier_hold combo=%0d max=%0d score=%0d exp 255/255/%0d",
                  combo, max_combo, score, m_score[0]);
      end
   endtask

   task automatic test_conflict();
      int prev;
      cycle(SS, 2'b00, 2'b00, 2'b00);
      for (int i = 0; i < 10; i++) cycle(GP, 2'b11, 2'b00, 2'b00);
      cycle(GP, 2'b00, 2'b00, 2'b00);
      prev = m_score[0];
      total++;
      if (combo !== 8'd20 || score !== 16'(prev)) begin
         bad++;
         $display("FAIL conflict_prep combo=%0d score=%0d exp 20/%0d", combo, score, prev);
      end
      cycle(GP, 2'b11, 2'b00, 2'b01);
      total++;
      if (combo !== 8'd0 || max_combo !== 8'd20 || multiplier !== 5'd1) begin
         bad++;
         $display("FAIL conflict_combo combo=%0d max=%0d mult=%0d exp 0/20/1", combo, max_combo, multiplier);
      end
      cycle(GP, 2'b00, 2'b00, 2'b00);
      total++;
      if (score !== 16'(prev + 6) || score_upd !== 1'b1) begin
         bad++;
         $display("FAIL conflict_pts score=%0d upd=%0d exp %0d/1", score, score_upd, prev + 6);
      end
   endtask

   task automatic test_saturation();
      cycle(SS, 2'b00, 2'b00, 2'b00);
      for (int i = 0; i < 30; i++) cycle(GP, 2'b11, 2'b11, 2'b00);
      total++;
      if (score8 !== 8'd255 || saturated8 !== 1'b1 || saturated !== 1'b0 || score !== 16'(m_score[0])) begin
         bad++;
         $display("FAIL sat_clamp score8=%0d sat8=%0d sat16=%0d score16=%0d exp 255/1/0/%0d",
                  score8, saturated8, saturated, score, m_score[0]);
      end
      for (int i = 0; i < 3; i++) cycle(GP, 2'b00, 2'b00, 2'b00);
      total++;
      if (score8 !== 8'd255 || saturated8 !== 1'b1) begin
         bad++;
         $display("FAIL sat_sticky score8=%0d sat8=%0d exp 255/1", score8, saturated8);
      end
      cycle(SS, 2'b00, 2'b00, 2'b00);
      total++;
      if (score8 !== 8'd0 || saturated8 !== 1'b0) begin
         bad++;
         $display("FAIL sat_clear score8=%0d sat8=%0d exp 0/0", score8, saturated8);
      end
   endtask

   task automatic test_gating();
      int prev;
      cycle(SS, 2'b00, 2'b00, 2'b00);
      for (int i = 0; i < 3; i++) cycle(GP, 2'b01, 2'b01, 2'b00);
      cycle(GP, 2'b00, 2'b00, 2'b00);
      prev = m_score[0];
      cycle(GO, 2'b11, 2'b11, 2'b00);
      cycle(GO, 2'b11, 2'b11, 2'b10);
      total++;
      if (combo !== 8'd3 || max_combo !== 8'd3 || score !== 16'(prev) || score_upd !== 1'b0) begin
         bad++;
         $display("FAIL gate_over combo=%0d max=%0d score=%0d upd=%0d exp 3/3/%0d/0",
                  combo, max_combo, score, score_upd, prev);
      end
      cycle(GP, 2'b01, 2'b01, 2'b00);
      cycle(GO, 2'b00, 2'b00, 2'b00);
      total++;
      if (score !== 16'(prev + 8) || score_upd !== 1'b1 || combo !== 8'd4) begin
         bad++;
         $display("FAIL gate_last score=%0d upd=%0d combo=%0d exp %0d/1/4", score, score_upd, combo, prev + 8);
      end
      prev = prev + 8;
      cycle(GP, 2'b10, 2'b00, 2'b00);
      cycle(IDLE, 2'b11, 2'b11, 2'b00);
      total++;
      if (score !== 16'(prev + 4) || combo !== 8'd5) begin
         bad++;
         $display("FAIL gate_idle score=%0d combo=%0d exp %0d/5", score, combo, prev + 4);
      end
      cycle(GP, 2'b01, 2'b01, 2'b00);
      cycle(SS, 2'b00, 2'b00, 2'b00);
      cycle(IDLE, 2'b00, 2'b00, 2'b00);
      total++;
      if (score !== 16'd0 || combo !== 8'd0 || score_upd !== 1'b0) begin
         bad++;
         $display("FAIL gate_flush score=%0d combo=%0d upd=%0d exp 0/0/0", score, combo, score_upd);
      end
   endtask

   task automatic test_random();
      logic [1:0] s, h, p, m;
      int r;
      cycle(SS, 2'b00, 2'b00, 2'b00);
      for (int n = 0; n < 400; n++) begin
         r = $urandom_range(0, 19);
         s = (r == 0) ? SS : (r == 1) ? IDLE : (r == 2) ? GO : GP;
         h = 2'($urandom_range(0, 3));
         p = 2'($urandom_range(0, 3));
         m = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
         cycle(s, h, p, m);
         total++;
         if (score !== 16'(m_score[0]) || score8 !== 8'(m_score[1]) ||
             combo !== 8'(m_combo) || max_combo !== 8'(m_max) ||
             multiplier !== 5'(mult_ref(m_combo)) ||
             score_upd !== 1'(m_upd[0]) || saturated !== 1'(m_sat[0]) ||
             score_upd8 !== 1'(m_upd[1]) || saturated8 !== 1'(m_sat[1]) ||
             combo8 !== 8'(m_combo) || max_combo8 !== 8'(m_max) ||
             multiplier8 !== 5'(mult_ref(m_combo))) begin
            bad++;
            $display("FAIL random[%0d] got score=%0d s8=%0d combo=%0d max=%0d mult=%0d upd=%0d/%0d sat=%0d/%0d exp score=%0d s8=%0d combo=%0d max=%0d mult=%0d upd=%0d/%0d sat=%0d/%0d",
                     n, score, score8, combo, max_combo, multiplier, score_upd, score_upd8,
                     saturated, saturated8, m_score[0], m_score[1], m_combo, m_max,
                     mult_ref(m_combo), m_upd[0], m_upd[1], m_sat[0], m_sat[1]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_tiers();
      test_conflict();
      test_saturation();
      test_gating();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
